mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as the responder on the RISC-V processor's data-memory bus. Core stores to its DATA register are queued in a small FIFO and serialized onto a single `tx` line. Loads from its STATUS register report FIFO and line state. It sits beside data memory in the top-level processor and is the core's output path to the outside world. It is driven by the same `clk`/`reset` that the processor bench supplies.

---
 rtl/mmio_uart_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 42 ++++
 rtl/mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// The optional parity state is used only when UART_TX_PARITY_EN is defined.
package mmio_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam int unsigned ST_FULL  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_BUSY  = 2;
  localparam int unsigned ST_OVF   = 3;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter. Pointers carry one extra wrap bit so that
// full and empty fall out of a plain compare.
module uart_tx_fifo #(
  parameter int unsigned Depth = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [Depth];
  logic        do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: DATA stores are queued and sent 8N1, or 8E1
// when UART_TX_PARITY_EN is defined. STATUS reports FIFO/line state.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] read_data,
  output logic        sel,
  output logic        tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic        data_hit, status_hit, data_wr, status_wr;
  logic        fifo_full, fifo_empty, pop, busy, baud_last;
  logic [7:0]  fifo_rdata;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^{write_data[31:8], write_data[7:4], write_data[2:0]};

  assign data_hit   = (addr == BASE_ADDR + DATA_OFS);
  assign status_hit = (addr == BASE_ADDR + STATUS_OFS);
  assign sel        = data_hit || status_hit;
  assign data_wr    = mem_write && data_hit;
  assign status_wr  = mem_write && status_hit;
  assign busy       = (state_q != StIdle);
  assign baud_last  = (baud_q == BaudLast);

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .wdata (write_data[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_BUSY]  = busy;
    status[ST_OVF]   = ovf_q;
    read_data        = (mem_read && status_hit) ? status : 32'd0;
  end

  // A store that finds the FIFO full is lost even if a pop frees a slot this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (data_wr && fifo_full)                ovf_d = 1'b1;
    else if (status_wr && write_data[ST_OVF]) ovf_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + CW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_rdata;
`endif
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames are contiguous.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Line level is registered from next-state values to keep tx glitch-free.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: expected frames and load responses are queued
// by the stimulus and checked by independent monitors on the tx line and read port.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] read_data;
  logic        sel;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .read_data  (read_data),
    .sel        (sel),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         contig;
  } frame_t;

  typedef struct {
    logic [31:0] data;
    logic        sel;
  } rd_t;

  frame_t fq[$];
  rd_t    rq[$];
  int     total = 0;
  int     passed = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; write_data = d; mem_write = 1'b1;
    tick(1);
    mem_write = 1'b0; addr = '0; write_data = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input logic exp_sel);
    rd_t e;
    e.data = exp; e.sel = exp_sel;
    rq.push_back(e);
    addr = a; mem_read = 1'b1;
    tick(1);
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit contig);
    frame_t f;
    f.data = d; f.contig = contig;
    fq.push_back(f);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (fq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(fq.size() == 0, name, fq.size(), 0);
    tick(3);
  endtask

  // Read-port monitor.
  initial begin : read_mon
    rd_t e;
    forever begin
      @(negedge clk);
      if (mem_read === 1'b1) begin
        if (rq.size() == 0) begin
          check(1'b0, "read_unexpected", read_data, 0);
        end else begin
          e = rq.pop_front();
          check(read_data === e.data, "read_data", read_data, e.data);
          check(sel === e.sel, "read_sel", {31'b0, sel}, {31'b0, e.sel});
        end
      end
    end
  end

  // Line monitor: decodes each frame, checks bit widths, data, parity, stop, gaps.
  initial begin : frame_mon
    logic [NBITS-1:0] bits;
    bit     steady;
    int     start_cyc;
    int     prev_end;
    frame_t e;
    prev_end = -100;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        start_cyc = cyc;
        steady    = 1'b1;
        bits      = '0;
        for (int b = 0; b < NBITS; b++) begin
          for (int k = 0; k < CPB; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) bits[b] = tx;
            else if (tx !== bits[b]) steady = 1'b0;
          end
        end
        if (fq.size() == 0) begin
          check(1'b0, "frame_unexpected", {{(32-NBITS){1'b0}}, bits}, 0);
        end else begin
          e = fq.pop_front();
          check(bits[8:1] === e.data, "frame_data", bits[8:1], e.data);
          check(steady, "bit_width", steady, 1);
          check(bits[NBITS-1] === 1'b1, "stop_bit", bits[NBITS-1], 1);
`ifdef UART_TX_PARITY_EN
          check(bits[9] === ^e.data, "parity_bit", bits[9], ^e.data);
`endif
          if (e.contig)
            check(start_cyc == prev_end + 1, "contiguous", start_cyc, prev_end + 1);
        end
        prev_end = cyc;
      end
    end
  end

  initial begin : stim
    tick(3);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check(tx === 1'b1, "idle_tx", tx, 1);
    end
    tick(1);
    mon_en = 1'b1;
    rd(BASE + 4, 32'h2, 1'b1);
    rd(BASE, 32'h0, 1'b1);

    // Single byte; busy while sending, empty and idle after.
    expect_frame(8'h55, 1'b0);
    wr(BASE, 32'h55);
    tick(10);
    rd(BASE + 4, 32'h6, 1'b1);
    wait_drain("drain_single");
    rd(BASE + 4, 32'h2, 1'b1);

    // Three back-to-back stores give contiguous frames.
    expect_frame(8'h41, 1'b0);
    expect_frame(8'h42, 1'b1);
    expect_frame(8'h43, 1'b1);
    wr(BASE, 32'h41);
    wr(BASE, 32'h42);
    wr(BASE, 32'hFFFF_FF43);
    wait_drain("drain_three");

    // Parity-sensitive byte.
    expect_frame(8'h07, 1'b0);
    wr(BASE, 32'h07);
    wait_drain("drain_07");

    // Unmapped address is ignored.
    rd(BASE + 8, 32'h0, 1'b0);
    wr(BASE + 8, 32'h99);
    wr(BASE + 8, 32'h8);
    tick(60);
    rd(BASE + 4, 32'h2, 1'b1);

    // Overflow: 10 stores, 9 accepted.
    for (int i = 0; i < 9; i++) expect_frame(8'(8'h10 + i), i != 0);
    for (int i = 0; i < 10; i++) wr(BASE, 32'(8'h10 + i));
    rd(BASE + 4, 32'hD, 1'b1);
    wr(BASE + 4, 32'h8);
    rd(BASE + 4, 32'h5, 1'b1);
    wait_drain("drain_overflow");
    rd(BASE + 4, 32'h2, 1'b1);

    // Reset in the middle of a frame discards it and anything queued.
    mon_en = 1'b0;
    wr(BASE, 32'hA5);
    wr(BASE, 32'h5A);
    tick(12);
    rd(BASE + 4, 32'h4, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check(tx === 1'b1, "reset_tx", tx, 1);
    tick(1);
    mon_en = 1'b1;
    rd(BASE + 4, 32'h2, 1'b1);
    tick(100);
    check(tx === 1'b1, "post_reset_tx", tx, 1);
    wait_drain("final_drain");
    check(rq.size() == 0, "read_queue_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
